sram_dp_param: RTL

- Parametrised simple-dual-port synchronous SRAM: one write port, one read port, independent addresses, one shared clock.
- Next generation of the team's 8x8 SRAM. Adds:
  - parametrised width and depth
  - byte-lane write enables
  - a registered read with a valid strobe, replacing the tri-state output
  - selectable read-during-write collision mode
  - a hardware clear sequencer that initialises every word after reset
- Used as the generic on-chip buffer for FIFOs and register files.

---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_clear_seq.sv | 39 +++
 rtl/sram_dp_param.sv | 76 +++++++
 3 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types, read-mode constants and byte-lane merge for the dual-port SRAM
package sram_pkg;

  typedef enum logic {CLEAR, READY} state_t;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MAX_W  = 1024;
  localparam int MAX_BE = MAX_W / 8;

  function automatic logic [MAX_W-1:0] be_merge(input logic [MAX_W-1:0]  old_word,
                                                input logic [MAX_W-1:0]  new_word,
                                                input logic [MAX_BE-1:0] be);
    logic [MAX_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_BE; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// rtl/sram_clear_seq.sv - post-reset clear sequencer: walks every address once, then releases busy
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter int              ADDR_W    = 3,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clok,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_add,
  output logic [DATA_W-1:0] clr_data
);

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;

  always_ff @(posedge clok) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == {ADDR_W{1'b1}}) begin
        state <= READY;
        busy  <= 1'b0;
      end
    end
  end

  // The reset edge itself must leave memory untouched.
  assign clr_we   = (state == CLEAR) && !rst;
  assign clr_add  = clr_ptr;
  assign clr_data = CLEAR_VAL;

endmodule

// File: rtl/sram_dp_param.sv
// rtl/sram_dp_param.sv - simple-dual-port SRAM with byte enables, registered read and hardware clear
module sram_dp_param
  import sram_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 3,
  parameter int                RD_MODE   = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                  clok,
  input  logic                  rst,
  input  logic                  wri,
  input  logic [ADDR_W-1:0]     wr_add,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  rd,
  input  logic [ADDR_W-1:0]     rd_add,
  output logic [DATA_W-1:0]     data_out,
  output logic                  rd_valid,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  generate
    if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > MAX_W) begin : g_bad_width
      $error("sram_dp_param: DATA_W must be a positive multiple of 8");
    end
  endgenerate

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] clr_data;
  logic [ADDR_W-1:0] clr_add;
  logic              clr_we;
  logic              user_ok;

  sram_clear_seq #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .CLEAR_VAL (CLEAR_VAL)
  ) u_clear_seq (
    .clok     (clok),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_add  (clr_add),
    .clr_data (clr_data)
  );

  assign user_ok = !busy && !rst;
  assign merged  = DATA_W'(be_merge(MAX_W'(ram[wr_add]), MAX_W'(data_in), MAX_BE'(wr_be)));

  always_ff @(posedge clok) begin
    if (clr_we) begin
      ram[clr_add] <= clr_data;
    end else if (user_ok && wri) begin
      ram[wr_add] <= merged;
    end
  end

  // Write-first bypasses the array so a same-edge read sees the merged word.
  always_ff @(posedge clok) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else if (user_ok && rd) begin
      rd_valid <= 1'b1;
      if (RD_MODE == WR_FIRST && wri && wr_add == rd_add) data_out <= merged;
      else                                                data_out <= ram[rd_add];
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule
